// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, stall, flush and forwarding control for the 5-stage pipeline
// One FSM owns every inter-stage enable/flush; forward selects and perf counters are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_en,
  output logic                  em_en,
  output logic                  mw_en,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_LDSTALL = 2'b01,
    S_FLUSH   = 2'b10,
    S_MEMWAIT = 2'b11
  } state_t;

  localparam logic [1:0] LD_REM = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_REM = 2'(FLUSH_DEPTH - 1);

  state_t     cur_state;
  state_t     saved_state;
  logic [1:0] remaining;
  logic [1:0] saved_rem;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic load_use, branch;
  logic [1:0] fwd_a_next, fwd_b_next;

  function automatic logic rd_ok(input logic [REG_ADDR_W-1:0] rd);
    return (ZERO_REG_EN == 0) || (rd != '0);
  endfunction

  assign ex_hit_rs1  = ex_valid && ex_regwrite && (ex_rd == id_rs1) && rd_ok(ex_rd);
  assign ex_hit_rs2  = id_uses_rs2 && ex_valid && ex_regwrite && (ex_rd == id_rs2) && rd_ok(ex_rd);
  assign mem_hit_rs1 = mem_valid && mem_regwrite && (mem_rd == id_rs1) && rd_ok(mem_rd);
  assign mem_hit_rs2 = id_uses_rs2 && mem_valid && mem_regwrite && (mem_rd == id_rs2) && rd_ok(mem_rd);

  // A load in EX cannot forward yet; its consumer must stall instead.
  assign fwd_a_next = (ex_hit_rs1 && !ex_memread) ? 2'b01 : (mem_hit_rs1 ? 2'b10 : 2'b00);
  assign fwd_b_next = (ex_hit_rs2 && !ex_memread) ? 2'b01 : (mem_hit_rs2 ? 2'b10 : 2'b00);

  assign branch   = (cur_state == S_RUN) && br_taken && ex_valid;
  assign load_use = (cur_state == S_RUN) && id_valid && ex_memread && (ex_hit_rs1 || ex_hit_rs2);

  assign state = cur_state;

  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    if (!mem_ready) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else begin
      case (cur_state)
        S_RUN: begin
          if (branch) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
          end
        end
        S_LDSTALL: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
        end
        S_FLUSH: fd_flush = 1'b1;
        // MEMWAIT with memory ready again: one pass-through cycle while the saved state returns.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cur_state   <= S_RUN;
      saved_state <= S_RUN;
      remaining   <= 2'd0;
      saved_rem   <= 2'd0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (fd_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);

      if (de_bubble) begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else if (de_en) begin
        fwd_a <= fwd_a_next;
        fwd_b <= fwd_b_next;
      end

      if (!mem_ready) begin
        // Save only on entry so a long wait keeps the original context.
        if (cur_state != S_MEMWAIT) begin
          saved_state <= cur_state;
          saved_rem   <= remaining;
        end
        cur_state <= S_MEMWAIT;
      end else begin
        case (cur_state)
          S_RUN: begin
            if (branch) begin
              if (FLUSH_DEPTH > 1) begin
                cur_state <= S_FLUSH;
                remaining <= FL_REM;
              end
            end else if (load_use) begin
              if (LOAD_LAT > 1) begin
                cur_state <= S_LDSTALL;
                remaining <= LD_REM;
              end
            end
          end
          S_LDSTALL, S_FLUSH: begin
            remaining <= remaining - 2'd1;
            if (remaining == 2'd1)
              cur_state <= S_RUN;
          end
          default: begin
            cur_state <= saved_state;
            remaining <= saved_rem;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl
// Two instances: A (LOAD_LAT=2, FLUSH_DEPTH=3, CNT_W=16) and B (LOAD_LAT=3, FLUSH_DEPTH=1, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst, id_valid, id_uses_rs2, ex_valid, ex_regwrite, ex_memread;
  logic       mem_valid, mem_regwrite, br_taken, mem_ready;
  logic [3:0] id_rs1, id_rs2, ex_rd, mem_rd;

  logic        a_pc_en, a_fd_en, a_de_en, a_em_en, a_mw_en, a_fd_flush, a_de_bubble;
  logic        b_pc_en, b_fd_en, b_de_en, b_em_en, b_mw_en, b_fd_flush, b_de_bubble;
  logic [1:0]  a_fwd_a, a_fwd_b, a_state, b_fwd_a, b_fwd_b, b_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  logic [4:0]  en_o [2];
  logic        flush_o [2];
  logic        bub_o [2];
  logic [1:0]  fa_o [2];
  logic [1:0]  fb_o [2];
  logic [1:0]  st_o [2];
  logic [15:0] sc_o [2];
  logic [15:0] fc_o [2];

  assign en_o[0] = {a_pc_en, a_fd_en, a_de_en, a_em_en, a_mw_en};
  assign en_o[1] = {b_pc_en, b_fd_en, b_de_en, b_em_en, b_mw_en};
  assign flush_o[0] = a_fd_flush;
  assign flush_o[1] = b_fd_flush;
  assign bub_o[0] = a_de_bubble;
  assign bub_o[1] = b_de_bubble;
  assign fa_o[0] = a_fwd_a;
  assign fa_o[1] = b_fwd_a;
  assign fb_o[0] = a_fwd_b;
  assign fb_o[1] = b_fwd_b;
  assign st_o[0] = a_state;
  assign st_o[1] = b_state;
  assign sc_o[0] = a_stall_cnt;
  assign sc_o[1] = {12'd0, b_stall_cnt};
  assign fc_o[0] = a_flush_cnt;
  assign fc_o[1] = {12'd0, b_flush_cnt};

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(2), .FLUSH_DEPTH(3), .ZERO_REG_EN(1), .CNT_W(16)) dut_a (
    .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .br_taken(br_taken), .mem_ready(mem_ready),
    .pc_en(a_pc_en), .fd_en(a_fd_en), .de_en(a_de_en), .em_en(a_em_en), .mw_en(a_mw_en),
    .fd_flush(a_fd_flush), .de_bubble(a_de_bubble), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .state(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(3), .FLUSH_DEPTH(1), .ZERO_REG_EN(1), .CNT_W(4)) dut_b (
    .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .br_taken(br_taken), .mem_ready(mem_ready),
    .pc_en(b_pc_en), .fd_en(b_fd_en), .de_en(b_de_en), .em_en(b_em_en), .mw_en(b_mw_en),
    .fd_flush(b_fd_flush), .de_bubble(b_de_bubble), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b00111;
  localparam logic [4:0] EN_NONE  = 5'b00000;

  task automatic set_idle();
    rst = 1'b0; id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 4'd0;
    mem_valid = 1'b0; mem_regwrite = 1'b0; mem_rd = 4'd0; br_taken = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_load_use();
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 4'd5;
    id_valid = 1'b1; id_rs1 = 4'd1; id_rs2 = 4'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    set_idle();
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    set_idle();
    rst = 1'b1; br_taken = 1'b1; ex_valid = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    set_idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (st_o[k] !== 2'd0) begin bad++; $display("FAIL reset_state dut%0d got=%0d want=0", k, st_o[k]); end
      total++; if (en_o[k] !== EN_ALL) begin bad++; $display("FAIL reset_en dut%0d got=%b want=%b", k, en_o[k], EN_ALL); end
      total++; if ({flush_o[k], bub_o[k]} !== 2'b00) begin bad++; $display("FAIL reset_flush_bub dut%0d got=%b want=00", k, {flush_o[k], bub_o[k]}); end
      total++; if ({fa_o[k], fb_o[k]} !== 4'd0) begin bad++; $display("FAIL reset_fwd dut%0d got=%b want=0000", k, {fa_o[k], fb_o[k]}); end
      total++; if (sc_o[k] !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt dut%0d got=%0d want=0", k, sc_o[k]); end
      total++; if (fc_o[k] !== 16'd0) begin bad++; $display("FAIL reset_flush_cnt dut%0d got=%0d want=0", k, fc_o[k]); end
    end
  endtask

  task automatic test_ex_forward();
    @(negedge clock);
    set_idle();
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_rd = 4'd3;
    id_valid = 1'b1; id_rs1 = 4'd3; id_rs2 = 4'd3; id_uses_rs2 = 1'b1;
    @(negedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({fa_o[k], fb_o[k]} !== 4'b0101) begin bad++; $display("FAIL fwd_ex dut%0d got=%b want=0101", k, {fa_o[k], fb_o[k]}); end
    end
    ex_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
    @(negedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({fa_o[k], fb_o[k]} !== 4'b0000) begin bad++; $display("FAIL fwd_zero_reg dut%0d got=%b want=0000", k, {fa_o[k], fb_o[k]}); end
    end
    ex_valid = 1'b0; mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 4'd7;
    id_rs1 = 4'd7; id_rs2 = 4'd7; id_uses_rs2 = 1'b0;
    @(negedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({fa_o[k], fb_o[k]} !== 4'b1000) begin bad++; $display("FAIL fwd_mem_rs2_unused dut%0d got=%b want=1000", k, {fa_o[k], fb_o[k]}); end
    end
    ex_valid = 1'b1; ex_rd = 4'd7; id_uses_rs2 = 1'b1;
    @(negedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({fa_o[k], fb_o[k]} !== 4'b0101) begin bad++; $display("FAIL fwd_ex_over_mem dut%0d got=%b want=0101", k, {fa_o[k], fb_o[k]}); end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({en_o[k], bub_o[k]} !== {EN_STALL, 1'b1}) begin bad++; $display("FAIL lu_c0 dut%0d got=%b want=%b", k, {en_o[k], bub_o[k]}, {EN_STALL, 1'b1}); end
    end
    @(negedge clock);
    ex_valid = 1'b0; ex_memread = 1'b0;
    #1;
    total++; if ({en_o[0], bub_o[0]} !== {EN_STALL, 1'b1}) begin bad++; $display("FAIL lu_c1_a got=%b want=%b", {en_o[0], bub_o[0]}, {EN_STALL, 1'b1}); end
    total++; if (st_o[0] !== 2'd1) begin bad++; $display("FAIL lu_c1_state_a got=%0d want=1", st_o[0]); end
    @(negedge clock); #1;
    total++; if ({en_o[0], bub_o[0]} !== {EN_ALL, 1'b0}) begin bad++; $display("FAIL lu_c2_a got=%b want=%b", {en_o[0], bub_o[0]}, {EN_ALL, 1'b0}); end
    total++; if (st_o[0] !== 2'd0) begin bad++; $display("FAIL lu_c2_state_a got=%0d want=0", st_o[0]); end
    total++; if (sc_o[0] !== 16'd2) begin bad++; $display("FAIL lu_stall_cnt_a got=%0d want=2", sc_o[0]); end
    total++; if ({st_o[1], en_o[1]} !== {2'd1, EN_STALL}) begin bad++; $display("FAIL lu_c2_b got=%b want=%b", {st_o[1], en_o[1]}, {2'd1, EN_STALL}); end
    @(negedge clock); #1;
    total++; if ({st_o[1], en_o[1]} !== {2'd0, EN_ALL}) begin bad++; $display("FAIL lu_c3_b got=%b want=%b", {st_o[1], en_o[1]}, {2'd0, EN_ALL}); end
    total++; if (sc_o[1] !== 16'd3) begin bad++; $display("FAIL lu_stall_cnt_b got=%0d want=3", sc_o[1]); end
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use();
    br_taken = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if ({en_o[k], flush_o[k], bub_o[k]} !== {EN_ALL, 2'b11}) begin bad++; $display("FAIL br_c0 dut%0d got=%b want=%b", k, {en_o[k], flush_o[k], bub_o[k]}, {EN_ALL, 2'b11}); end
    end
    @(negedge clock);
    br_taken = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0;
    #1;
    total++; if ({st_o[0], flush_o[0], bub_o[0]} !== {2'd2, 2'b10}) begin bad++; $display("FAIL br_c1_a got=%b want=%b", {st_o[0], flush_o[0], bub_o[0]}, {2'd2, 2'b10}); end
    total++; if ({st_o[1], flush_o[1]} !== {2'd0, 1'b0}) begin bad++; $display("FAIL br_c1_b got=%b want=000", {st_o[1], flush_o[1]}); end
    @(negedge clock);
    br_taken = 1'b1; ex_valid = 1'b1;
    #1;
    total++; if ({st_o[0], flush_o[0], bub_o[0], en_o[0]} !== {2'd2, 2'b10, EN_ALL}) begin bad++; $display("FAIL br_c2_a got=%b want=%b", {st_o[0], flush_o[0], bub_o[0], en_o[0]}, {2'd2, 2'b10, EN_ALL}); end
    total++; if ({flush_o[1], bub_o[1]} !== 2'b11) begin bad++; $display("FAIL br_c2_b got=%b want=11", {flush_o[1], bub_o[1]}); end
    @(negedge clock);
    set_idle();
    #1;
    total++; if ({st_o[0], flush_o[0]} !== 3'b000) begin bad++; $display("FAIL br_c3_a got=%b want=000", {st_o[0], flush_o[0]}); end
    total++; if (fc_o[0] !== 16'd3) begin bad++; $display("FAIL br_flush_cnt_a got=%0d want=3", fc_o[0]); end
    total++; if (fc_o[1] !== 16'd2) begin bad++; $display("FAIL br_flush_cnt_b got=%0d want=2", fc_o[1]); end
    total++; if ({sc_o[0], sc_o[1]} !== 32'd0) begin bad++; $display("FAIL br_no_stall got=%0d/%0d want=0/0", sc_o[0], sc_o[1]); end
  endtask

  task automatic test_memwait();
    do_reset();
    set_load_use();
    #1;
    total++; if (en_o[1] !== EN_STALL) begin bad++; $display("FAIL mw_c0_b got=%b want=%b", en_o[1], EN_STALL); end
    @(negedge clock);
    set_idle();
    mem_ready = 1'b0;
    #1;
    total++; if ({st_o[1], en_o[1]} !== {2'd1, EN_NONE}) begin bad++; $display("FAIL mw_c1_b got=%b want=%b", {st_o[1], en_o[1]}, {2'd1, EN_NONE}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      total++; if ({st_o[1], en_o[1], flush_o[1], bub_o[1]} !== {2'd3, EN_NONE, 2'b00}) begin bad++; $display("FAIL mw_wait%0d_b got=%b want=%b", i, {st_o[1], en_o[1], flush_o[1], bub_o[1]}, {2'd3, EN_NONE, 2'b00}); end
    end
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    total++; if ({st_o[1], en_o[1]} !== {2'd3, EN_ALL}) begin bad++; $display("FAIL mw_resume_b got=%b want=%b", {st_o[1], en_o[1]}, {2'd3, EN_ALL}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      total++; if ({st_o[1], en_o[1]} !== {2'd1, EN_STALL}) begin bad++; $display("FAIL mw_ldstall%0d_b got=%b want=%b", i, {st_o[1], en_o[1]}, {2'd1, EN_STALL}); end
    end
    @(negedge clock); #1;
    total++; if ({st_o[1], en_o[1]} !== {2'd0, EN_ALL}) begin bad++; $display("FAIL mw_done_b got=%b want=%b", {st_o[1], en_o[1]}, {2'd0, EN_ALL}); end
    total++; if (sc_o[1] !== 16'd7) begin bad++; $display("FAIL mw_stall_cnt_b got=%0d want=7", sc_o[1]); end
    total++; if (sc_o[0] !== 16'd6) begin bad++; $display("FAIL mw_stall_cnt_a got=%0d want=6", sc_o[0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_ready = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    total++; if (sc_o[1] !== 16'd15) begin bad++; $display("FAIL sat_stall_cnt_b got=%0d want=15", sc_o[1]); end
    total++; if (sc_o[0] !== 16'd20) begin bad++; $display("FAIL sat_stall_cnt_a got=%0d want=20", sc_o[0]); end
    total++; if ({st_o[0], st_o[1]} !== 4'b1111) begin bad++; $display("FAIL sat_state got=%b want=1111", {st_o[0], st_o[1]}); end
  endtask

  // Reference model: pending extra stall/flush cycles, a frozen flag, and saturating tallies.
  task automatic test_random();
    int  ll [2];
    int  fd [2];
    int  maxc [2];
    int  stall_left [2];
    int  flush_left [2];
    bit  waiting [2];
    logic [1:0] m_fa [2];
    logic [1:0] m_fb [2];
    int  m_sc [2];
    int  m_fc [2];
    bit  exh1, exh2, mh1, mh2, lu, brq;
    logic [1:0] na, nb, e_st;
    logic [4:0] e_en;
    bit  e_fl, e_bu;
    int  mode;
    ll[0] = 2; fd[0] = 3; maxc[0] = 65535;
    ll[1] = 3; fd[1] = 1; maxc[1] = 15;
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; waiting[k] = 0;
      m_fa[k] = 2'd0; m_fb[k] = 2'd0; m_sc[k] = 0; m_fc[k] = 0;
    end
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 4'($urandom_range(0, 3));
      id_rs2       = 4'($urandom_range(0, 3));
      id_uses_rs2  = ($urandom_range(0, 1) != 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_rd        = 4'($urandom_range(0, 3));
      mem_valid    = ($urandom_range(0, 3) != 0);
      mem_regwrite = ($urandom_range(0, 3) != 0);
      mem_rd       = 4'($urandom_range(0, 3));
      br_taken     = ($urandom_range(0, 5) == 0);
      mem_ready    = ($urandom_range(0, 6) != 0);
      #1;
      exh1 = ex_valid && ex_regwrite && (ex_rd == id_rs1) && (ex_rd != 0);
      exh2 = id_uses_rs2 && ex_valid && ex_regwrite && (ex_rd == id_rs2) && (ex_rd != 0);
      mh1  = mem_valid && mem_regwrite && (mem_rd == id_rs1) && (mem_rd != 0);
      mh2  = id_uses_rs2 && mem_valid && mem_regwrite && (mem_rd == id_rs2) && (mem_rd != 0);
      na   = (exh1 && !ex_memread) ? 2'd1 : (mh1 ? 2'd2 : 2'd0);
      nb   = (exh2 && !ex_memread) ? 2'd1 : (mh2 ? 2'd2 : 2'd0);
      lu   = id_valid && ex_memread && (exh1 || exh2);
      brq  = br_taken && ex_valid;
      for (int k = 0; k < 2; k++) begin
        if (!mem_ready)             mode = 0;
        else if (waiting[k])        mode = 1;
        else if (stall_left[k] > 0) mode = 2;
        else if (flush_left[k] > 0) mode = 3;
        else if (brq)               mode = 4;
        else if (lu)                mode = 5;
        else                        mode = 6;
        e_en = (mode == 0) ? EN_NONE : ((mode == 2 || mode == 5) ? EN_STALL : EN_ALL);
        e_fl = (mode == 3 || mode == 4);
        e_bu = (mode == 2 || mode == 4 || mode == 5);
        e_st = waiting[k] ? 2'd3 : (stall_left[k] > 0 ? 2'd1 : (flush_left[k] > 0 ? 2'd2 : 2'd0));
        total++; if (en_o[k] !== e_en) begin bad++; $display("FAIL rnd_en dut%0d cyc%0d got=%b want=%b", k, cyc, en_o[k], e_en); end
        total++; if (flush_o[k] !== e_fl) begin bad++; $display("FAIL rnd_flush dut%0d cyc%0d got=%b want=%b", k, cyc, flush_o[k], e_fl); end
        total++; if (bub_o[k] !== e_bu) begin bad++; $display("FAIL rnd_bubble dut%0d cyc%0d got=%b want=%b", k, cyc, bub_o[k], e_bu); end
        total++; if (st_o[k] !== e_st) begin bad++; $display("FAIL rnd_state dut%0d cyc%0d got=%0d want=%0d", k, cyc, st_o[k], e_st); end
        total++; if ({fa_o[k], fb_o[k]} !== {m_fa[k], m_fb[k]}) begin bad++; $display("FAIL rnd_fwd dut%0d cyc%0d got=%b want=%b", k, cyc, {fa_o[k], fb_o[k]}, {m_fa[k], m_fb[k]}); end
        total++; if (sc_o[k] !== 16'(m_sc[k])) begin bad++; $display("FAIL rnd_stall_cnt dut%0d cyc%0d got=%0d want=%0d", k, cyc, sc_o[k], m_sc[k]); end
        total++; if (fc_o[k] !== 16'(m_fc[k])) begin bad++; $display("FAIL rnd_flush_cnt dut%0d cyc%0d got=%0d want=%0d", k, cyc, fc_o[k], m_fc[k]); end

        if (!e_en[4] && m_sc[k] < maxc[k]) m_sc[k]++;
        if (e_fl && m_fc[k] < maxc[k]) m_fc[k]++;
        if (e_bu) begin
          m_fa[k] = 2'd0; m_fb[k] = 2'd0;
        end else if (e_en[2]) begin
          m_fa[k] = na; m_fb[k] = nb;
        end
        case (mode)
          0: waiting[k] = 1;
          1: waiting[k] = 0;
          2: stall_left[k]--;
          3: flush_left[k]--;
          4: flush_left[k] = fd[k] - 1;
          5: stall_left[k] = ll[k] - 1;
          default: ;
        endcase
      end
      @(negedge clock);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_branch();
    test_memwait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, stall, flush and forwarding controller for the 5-stage 16-bit pipeline (fetch, decode, execute, mem, writeback).
- Replaces the separate hazard-detection and forward units with one FSM-driven block.
- Adds multi-cycle load-use stalls, configurable branch flush depth, a memory-ready wait handshake, registered forward selects and saturating performance counters.
- Drives every inter-stage register enable and flush from a single point.

Parameters:
REG_ADDR_W, 4, register-address width
LOAD_LAT, 1, bubble cycles inserted on a load-use hazard (1..3)
FLUSH_DEPTH, 1, cycles fd_flush is held after a taken branch (1..3)
ZERO_REG_EN, 1, when 1 register 0 never causes a hazard or a forward
CNT_W, 16, width of the performance counters

Ports:
clock  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a real instruction
id_rs1  in  REG_ADDR_W  decode source 1
id_rs2  in  REG_ADDR_W  decode source 2
id_uses_rs2  in  1  rs2 is actually read
ex_valid, ex_regwrite, ex_memread  in  1 each  execute-stage qualifiers
ex_rd  in  REG_ADDR_W  execute destination
mem_valid, mem_regwrite  in  1 each  mem-stage qualifiers
mem_rd  in  REG_ADDR_W  mem destination
br_taken  in  1  branch resolved taken in execute (qualified by ex_valid)
mem_ready  in  1  data memory ready; low = access not complete
pc_en, fd_en, de_en, em_en, mw_en  out  1 each  register write enables, active-high
fd_flush  out  1  clear the fetch/decode register to NOP
de_bubble  out  1  load NOP (regwrite=0) into the decode/execute register
fwd_a, fwd_b  out  2 each  registered execute operand select: 00 regfile, 01 EX/MEM aluout, 10 WB data, 11 unused
state  out  2  00 RUN, 01 LDSTALL, 10 FLUSH, 11 MEMWAIT
stall_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset: when rst is high at a clock edge, state=RUN, the remaining-cycle counter and saved state clear, fwd_a=fwd_b=00, and both counters clear.
  - After reset: all enables 1, fd_flush=0, de_bubble=0.
- Enables, fd_flush and de_bubble are combinational from state and inputs. fwd_*, state and the counters are registered.
- A source matches when the stage is valid, the stage's regwrite is set, its rd equals the source, and (ZERO_REG_EN=0 or rd≠0). rs2 participates only if id_uses_rs2=1.
- Priority in every state: rst > mem_ready=0 > br_taken > load-use > normal.
- MEMWAIT (mem_ready=0, any state):
  - All five enables 0; flush and bubble 0; fwd held.
  - The current state and remaining count are saved and frozen.
  - Enter MEMWAIT on the next edge. Restore the saved state on the first edge with mem_ready=1.
  - stall_cnt increments every cycle mem_ready=0.
- RUN + br_taken (ex_valid=1):
  - fd_flush=1 and de_bubble=1 this cycle; enables stay 1.
  - If FLUSH_DEPTH>1, go to FLUSH with remaining=FLUSH_DEPTH-1.
- FLUSH: fd_flush=1, de_bubble=0; decrement each cycle; return to RUN when it reaches 0. br_taken is ignored in this state.
- Load-use (RUN, id_valid, ex_memread, and ex_rd matches a used source):
  - pc_en=0, fd_en=0, de_bubble=1; em_en and mw_en stay 1.
  - If LOAD_LAT>1, go to LDSTALL with remaining=LOAD_LAT-1.
- LDSTALL: same outputs as the load-use cycle; decrement each cycle; return to RUN at 0.
- A branch and a load-use in the same cycle resolve as a branch; the load-use is discarded.
- Forward selects are computed per source each cycle:
  - EX match (non-load) → 01; else MEM match → 10; else 00. The EX match wins when both match.
  - Registered when de_en=1 and de_bubble=0. Cleared to 00 when de_bubble=1. Held when de_en=0.
- Counters:
  - stall_cnt increments on every cycle with pc_en=0.
  - flush_cnt increments on every cycle with fd_flush=1.
  - Both saturate at all-ones.

Test Plan:
- Reset: hold rst 2 cycles with br_taken=1, mem_ready=0 → after release state=00, all enables=1, fwd=00, both counters=0.
- EX forward: ex_rd=3 (regwrite, not load), id_rs1=3, id_rs2=3, id_uses_rs2=1 → next cycle fwd_a=01, fwd_b=01. Repeat with ex_rd=0 → fwd=00.
- Load-use, LOAD_LAT=2: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → pc_en=fd_en=0 and de_bubble=1 for exactly 2 cycles; stall_cnt=2; then RUN.
- Branch, FLUSH_DEPTH=3: br_taken pulse → fd_flush high 3 cycles, de_bubble only in the first; flush_cnt=3. A simultaneous load-use produces no stall.
- Memory wait mid-LDSTALL (LOAD_LAT=3): drop mem_ready for 4 cycles after the first stall cycle → all enables 0 and state=11 for 4 cycles, then 2 more LDSTALL cycles; stall_cnt=7.
- Saturation, CNT_W=4: 20 consecutive mem_ready=0 cycles → stall_cnt=15.
